regs: RTL and testbench
=======================

REGS -- requirements
Module: regs

Interface
REQ-001 Clocking/reset SHALL be one clock with asynchronous, active-high reset, ports clk and rst.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 rs1_addr_i  input  5  decode-stage read address, port 1.
REQ-005 rs2_addr_i  input  5  decode-stage read address, port 2.
REQ-006 rs1_data_o  output  32  read data, port 1, combinational.
REQ-007 rs2_data_o  output  32  read data, port 2, combinational.
REQ-008 reg_wen_i  input  1  write-back enable from execute stage.
REQ-009 reg_waddr_i  input  5  write-back destination.
REQ-010 reg_wdata_i  input  32  write-back data.
REQ-011 dbg_req_i  input  1  debug access request, level.
REQ-012 dbg_we_i  input  1  debug access type: 1 write, 0 read.
REQ-013 dbg_addr_i  input  5  debug register index.
REQ-014 dbg_wdata_i  input  32  debug write data.
REQ-015 dbg_rdata_o  output  32  debug read data, registered.
REQ-016 dbg_ack_o  output  1  debug completion pulse, registered.

Function
REQ-017 Storage SHALL be 31 x 32-bit registers x1..x31; x0 SHALL always read 0 and ignore all writes.
REQ-018 Pipeline write SHALL occur on the rising clk edge when reg_wen_i=1 and reg_waddr_i!=0.
REQ-019 Both read ports SHALL be combinational from the address inputs with zero-cycle latency.
REQ-020 Debug FSM SHALL have states IDLE, WAIT, ACK, HOLD.
REQ-021 In IDLE with dbg_req_i=1, the FSM SHALL latch dbg_we_i, dbg_addr_i and dbg_wdata_i.
REQ-022 An IDLE debug read SHALL capture the pre-edge register content into dbg_rdata_o and go to ACK.
REQ-023 An IDLE debug write with reg_wen_i=0 SHALL write the register and go to ACK.
REQ-024 An IDLE debug write with reg_wen_i=1 SHALL go to WAIT without writing, so the pipeline has priority.
REQ-025 WAIT SHALL stay while reg_wen_i=1; with reg_wen_i=0 it SHALL perform the latched write and go to ACK.
REQ-026 ACK SHALL drive dbg_ack_o=1 for exactly one cycle, then go to HOLD.
REQ-027 HOLD SHALL stay until dbg_req_i=0, then go to IDLE, so each request yields exactly one ack.
REQ-028 Debug write to x0 SHALL be discarded but still acknowledged; debug read of x0 SHALL return 0.
REQ-029 dbg_rdata_o SHALL hold its value until the next debug read completes; debug writes SHALL not alter it.
REQ-030 A debug write and a pipeline write SHALL never update a register on the same edge.

Reset
REQ-031 rst=1 SHALL immediately clear x1..x31 to 0, FSM to IDLE, dbg_ack_o to 0 and dbg_rdata_o to 0.
REQ-032 Reset during WAIT, ACK or HOLD SHALL abort the transaction with no write and no ack.
REQ-033 Reset deassertion SHALL take effect at the next clk edge with no extra startup cycles.

Configuration
REQ-034 Macro REGS_BYPASS_EN SHALL control write-to-read forwarding.
REQ-035 With the macro defined: when reg_wen_i=1 and reg_waddr_i==rsN_addr_i!=0, rsN_data_o SHALL equal reg_wdata_i in the same cycle.
REQ-036 Without the macro: rsN_data_o SHALL return the stored, pre-write value; no forwarding path SHALL exist.
REQ-037 The debug path SHALL be identical in both builds.

Verification
REQ-038 Reset, then read x0..x31 on both ports -> all 0; write x0=0xFFFFFFFF -> x0 still reads 0.
REQ-039 reg_wen_i=1, waddr=5, wdata=0x12345678, rs1_addr=5 same cycle -> rs1_data_o=0x12345678 (BYPASS_EN) or 0 (not defined); next cycle 0x12345678 in both builds.
REQ-040 Debug read x5 (holding 0xA5A5A5A5) -> dbg_ack_o high exactly one cycle, 2 cycles after req; dbg_rdata_o=0xA5A5A5A5; req held high -> no second ack.
REQ-041 Debug write x7=0xDEADBEEF while reg_wen_i=1 for 3 cycles -> FSM in WAIT for 3 cycles, write lands after reg_wen_i drops, ack follows, pipeline writes intact.
REQ-042 Assert rst while in WAIT -> no dbg_ack_o, x7 reads 0, FSM in IDLE.
REQ-043 Debug write x0=0x1 -> ack issued, x0 reads 0.

Source files
------------

// File: rtl/regs.sv
// regs: 32 x 32-bit register file (x0 hardwired to zero), two combinational read
// ports and a debug access FSM. Define REGS_BYPASS_EN for write-to-read forwarding.
module regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        reg_wen_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_ack_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} dbg_state_t;

  dbg_state_t  r_state;
  dbg_state_t  w_state_nxt;
  logic [31:0] r_rf [0:31];
  logic        r_dbg_we;
  logic [4:0]  r_dbg_addr;
  logic [31:0] r_dbg_wdata;
  logic [31:0] r_dbg_rdata;
  logic        r_dbg_ack;

  logic        w_latch;
  logic        w_dbg_wr;
  logic        w_rd_cap;
  logic [4:0]  w_dbg_waddr;
  logic [31:0] w_dbg_wdata;
  logic        w_pipe_wr;
  logic [31:0] w_rs1_stored;
  logic [31:0] w_rs2_stored;

  assign w_pipe_wr = reg_wen_i && (reg_waddr_i != 5'd0);

  // Debug writes only fire while the pipeline is idle, so both never hit one edge.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_dbg_wr    = 1'b0;
    w_rd_cap    = 1'b0;
    w_dbg_waddr = r_dbg_addr;
    w_dbg_wdata = r_dbg_wdata;
    case (r_state)
      IDLE: begin
        if (dbg_req_i) begin
          w_latch     = 1'b1;
          w_dbg_waddr = dbg_addr_i;
          w_dbg_wdata = dbg_wdata_i;
          if (!dbg_we_i) begin
            w_rd_cap    = 1'b1;
            w_state_nxt = ACK;
          end else if (!reg_wen_i) begin
            w_dbg_wr    = 1'b1;
            w_state_nxt = ACK;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!reg_wen_i) begin
          w_dbg_wr    = r_dbg_we;
          w_state_nxt = ACK;
        end
      end
      ACK:     w_state_nxt = HOLD;
      HOLD:    if (!dbg_req_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
      r_dbg_we    <= 1'b0;
      r_dbg_addr  <= '0;
      r_dbg_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dbg_ack <= (r_state == ACK);
      if (w_rd_cap)
        r_dbg_rdata <= (dbg_addr_i == 5'd0) ? '0 : r_rf[dbg_addr_i];
      if (w_latch) begin
        r_dbg_we    <= dbg_we_i;
        r_dbg_addr  <= dbg_addr_i;
        r_dbg_wdata <= dbg_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_pipe_wr) begin
      r_rf[reg_waddr_i] <= reg_wdata_i;
    end else if (w_dbg_wr && (w_dbg_waddr != 5'd0)) begin
      r_rf[w_dbg_waddr] <= w_dbg_wdata;
    end
  end

  assign w_rs1_stored = (rs1_addr_i == 5'd0) ? '0 : r_rf[rs1_addr_i];
  assign w_rs2_stored = (rs2_addr_i == 5'd0) ? '0 : r_rf[rs2_addr_i];

`ifdef REGS_BYPASS_EN
  assign rs1_data_o = (w_pipe_wr && (reg_waddr_i == rs1_addr_i)) ? reg_wdata_i : w_rs1_stored;
  assign rs2_data_o = (w_pipe_wr && (reg_waddr_i == rs2_addr_i)) ? reg_wdata_i : w_rs2_stored;
`else
  assign rs1_data_o = w_rs1_stored;
  assign rs2_data_o = w_rs2_stored;
`endif

  assign dbg_rdata_o = r_dbg_rdata;
  assign dbg_ack_o   = r_dbg_ack;

endmodule

// File: tb/tb_regs.sv
// Testbench for regs: reference model array plus an ack/readback scoreboard
// drained by an independent monitor.
module tb_regs;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        reg_wen_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic        dbg_req_i, dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i, dbg_rdata_o;
  logic        dbg_ack_o;

  always #5 clk = ~clk;

  regs dut (
    .clk(clk), .rst(rst),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .reg_wen_i(reg_wen_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o)
  );

  typedef struct {
    bit          rd;
    logic [31:0] val;
  } exp_t;

  int          errs = 0;
  int          checks = 0;
  int          acks = 0;
  logic [31:0] m [32];
  logic [31:0] last_rd = '0;
  exp_t        q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_exp(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : m[a];
`ifdef REGS_BYPASS_EN
    if (reg_wen_i && reg_waddr_i == a && a != 5'd0) v = reg_wdata_i;
`endif
    return v;
  endfunction

  // Monitor: every ack must match a queued transaction; reads also carry data.
  always @(negedge clk) begin
    if (dbg_ack_o === 1'b1) begin
      acks++;
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_ack: got ack=1 expected none at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.rd) chk("dbg_rdata", dbg_rdata_o, e.val);
      end
    end
  end

  task automatic pipe_wr(input logic [4:0] a, input logic [31:0] d);
    reg_wen_i = 1'b1; reg_waddr_i = a; reg_wdata_i = d;
    tick();
    if (a != 5'd0) m[a] = d;
    reg_wen_i = 1'b0;
  endtask

  task automatic dbg_xact(input bit we, input logic [4:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    int   n = 0;
    int   a0;
    e.rd  = !we;
    e.val = (a == 5'd0) ? 32'h0 : m[a];
    q.push_back(e);
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
    do begin tick(); n++; end while (dbg_ack_o !== 1'b1 && n < 20);
    checks++;
    if (n != lat) begin
      errs++;
      $display("FAIL dbg_latency: got %0d cycles expected %0d", n, lat);
    end
    if (!we) last_rd = e.val;
    else if (a != 5'd0) m[a] = d;
    a0 = acks;
    dbg_addr_i = $urandom_range(0, 31);
    dbg_we_i = $urandom_range(0, 1);
    tick();
    chk("ack_one_cycle", {31'b0, dbg_ack_o}, 32'h0);
    tick(); tick();
    chk("single_ack_while_req_held", acks - a0, 32'h1);
    dbg_req_i = 1'b0;
    tick(); tick();
    chk("dbg_rdata_held", dbg_rdata_o, last_rd);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;
    rst = 1'b1;
    rs1_addr_i = '0; rs2_addr_i = '0;
    reg_wen_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    #1;
    chk("rst_ack", {31'b0, dbg_ack_o}, 32'h0);
    chk("rst_rdata", dbg_rdata_o, 32'h0);
    tick();
    rst = 1'b0;

    // Reset contents, then x0 ignores writes
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = i[4:0]; rs2_addr_i = 5'(31 - i);
      #1;
      chk("rst_rs1", rs1_data_o, 32'h0);
      chk("rst_rs2", rs2_data_o, 32'h0);
    end
    pipe_wr(5'd0, 32'hFFFF_FFFF);
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; #1;
    chk("x0_rs1", rs1_data_o, 32'h0);
    chk("x0_rs2", rs2_data_o, 32'h0);

    // Same-cycle read of a register being written
    reg_wen_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'h1234_5678;
    rs1_addr_i = 5'd5; #1;
    chk("same_cycle_rs1", rs1_data_o, rd_exp(5'd5));
    tick();
    m[5] = 32'h1234_5678;
    reg_wen_i = 1'b0; #1;
    chk("next_cycle_rs1", rs1_data_o, 32'h1234_5678);

    // Debug read, debug writes (including x0)
    pipe_wr(5'd5, 32'hA5A5_A5A5);
    dbg_xact(1'b0, 5'd5, 32'h0, 2);
    dbg_xact(1'b1, 5'd0, 32'h1, 2);
    rs1_addr_i = 5'd0; #1;
    chk("dbg_x0_write", rs1_data_o, 32'h0);
    dbg_xact(1'b0, 5'd0, 32'h0, 2);
    dbg_xact(1'b1, 5'd9, 32'hCAFE_F00D, 2);
    rs2_addr_i = 5'd9; #1;
    chk("dbg_write_x9", rs2_data_o, 32'hCAFE_F00D);

    // Debug write stalled by three pipeline writes
    fork
      dbg_xact(1'b1, 5'd7, 32'hDEAD_BEEF, 5);
      begin
        for (int i = 0; i < 3; i++) begin
          reg_wen_i = 1'b1; reg_waddr_i = 5'(10 + i); reg_wdata_i = 32'h100 + i;
          tick();
          m[10 + i] = 32'h100 + i;
        end
        reg_wen_i = 1'b0;
        rs1_addr_i = 5'd7; #1;
        chk("wait_no_write", rs1_data_o, m[7]);
      end
    join
    for (int i = 0; i < 4; i++) begin
      rs1_addr_i = (i == 3) ? 5'd7 : 5'(10 + i); #1;
      chk("after_wait", rs1_data_o, m[rs1_addr_i]);
    end

    // Reset while the FSM waits
    begin
      int a0;
      a0 = acks;
      reg_wen_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'h3333;
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'h55;
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 32; i++) m[i] = '0;
      #2;
      rs1_addr_i = 5'd7; rs2_addr_i = 5'd3;
      chk("rst_async_x7", rs1_data_o, 32'h0);
      chk("rst_async_x3", rs2_data_o, 32'h0);
      dbg_req_i = 1'b0; reg_wen_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("rst_no_ack", acks - a0, 32'h0);
      chk("rst_x7", rs1_data_o, 32'h0);
      last_rd = '0;
      chk("rst_dbg_rdata", dbg_rdata_o, 32'h0);
    end
    dbg_xact(1'b0, 5'd7, 32'h0, 2);

    // Random pipeline traffic against the model
    for (int k = 0; k < 300; k++) begin
      reg_wen_i   = ($urandom_range(0, 3) != 0);
      reg_waddr_i = $urandom_range(0, 31);
      reg_wdata_i = $urandom;
      rs1_addr_i  = ($urandom_range(0, 3) == 0) ? reg_waddr_i : 5'($urandom_range(0, 31));
      rs2_addr_i  = $urandom_range(0, 31);
      #1;
      chk("rand_rs1", rs1_data_o, rd_exp(rs1_addr_i));
      chk("rand_rs2", rs2_data_o, rd_exp(rs2_addr_i));
      tick();
      if (reg_wen_i && reg_waddr_i != 5'd0) m[reg_waddr_i] = reg_wdata_i;
    end
    reg_wen_i = 1'b0;

    // Random debug accesses
    for (int k = 0; k < 15; k++) begin
      logic [4:0] a;
      a = $urandom_range(0, 31);
      dbg_xact($urandom_range(0, 1), a, $urandom, 2);
      rs1_addr_i = a; #1;
      chk("rand_dbg_reg", rs1_data_o, (a == 5'd0) ? 32'h0 : m[a]);
    end

    tick(); tick();
    chk("queue_drained", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
